exp_core_rr_scheduler: RTL and testbench

//  Shares one iterative exp(x) core (S1.23.40, x in [-1,0]) among NUM_REQ requesters.

---
 rtl/exp_core_rr_scheduler.sv | 158 +++++++++++++++
 tb/tb_exp_core_rr_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_core_rr_scheduler.sv
// Round-robin front end that shares one iterative exp(x) core among NUM_REQ requesters.
// Optional operand clamping to [-1,0] is enabled with EXP_ARB_RANGE_CHECK_EN.
module exp_core_rr_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned FRAC_W  = 40
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_x,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_clamped,
    output logic [DATA_W-1:0]         core_x,
    output logic                      core_x_valid,
    input  logic                      core_x_ready,
    input  logic [DATA_W-1:0]         core_y,
    input  logic                      core_y_valid,
    output logic                      core_y_ready,
    output logic                      busy,
    output logic [15:0]               ops_done
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 16 || FRAC_W >= DATA_W) begin : g_param_check
        $error("exp_core_rr_scheduler: unsupported parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [DATA_W-1:0]  x_q, x_d;
    logic [DATA_W-1:0]  y_q, y_d;
    logic [15:0]        ops_q, ops_d;
    logic               clamp_q, clamp_d;

    logic [DATA_W-1:0]  req_x_arr [NUM_REQ];
    logic               gnt_found;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  sel_x;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_x_arr[i] = req_x[i*DATA_W +: DATA_W];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!gnt_found && req_valid[IDX_W'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    assign sel_x = req_x_arr[gnt_idx];

`ifdef EXP_ARB_RANGE_CHECK_EN
    localparam logic [DATA_W-1:0] NegOne = ~(DATA_W'(1) << FRAC_W) + DATA_W'(1);
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        x_d      = x_q;
        y_d      = y_q;
        ops_d    = ops_q;
        clamp_d  = clamp_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    grant_d  = gnt_idx;
                    rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d  = StIssue;
`ifdef EXP_ARB_RANGE_CHECK_EN
                    if (!sel_x[DATA_W-1] && (sel_x != '0)) begin
                        x_d     = '0;
                        clamp_d = 1'b1;
                    end else if ($signed(sel_x) < $signed(NegOne)) begin
                        x_d     = NegOne;
                        clamp_d = 1'b1;
                    end else begin
                        x_d     = sel_x;
                        clamp_d = 1'b0;
                    end
`else
                    x_d     = sel_x;
                    clamp_d = 1'b0;
`endif
                end
            end
            StIssue: begin
                if (core_x_ready) state_d = StWait;
            end
            StWait: begin
                if (core_y_valid) begin
                    y_d     = core_y;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready[grant_q]) begin
                    ops_d   = ops_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ops_q    <= '0;
            clamp_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ops_q    <= ops_d;
            clamp_q  <= clamp_d;
        end
    end

    assign req_ready    = (state_q == StIdle && gnt_found) ?
                          ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx) : '0;
    assign rsp_valid    = (state_q == StResp) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q) : '0;
    assign rsp_data     = y_q;
    assign core_x       = x_q;
    assign core_x_valid = (state_q == StIssue);
    assign core_y_ready = (state_q == StWait);
    assign busy         = (state_q != StIdle);
    assign ops_done     = ops_q;
`ifdef EXP_ARB_RANGE_CHECK_EN
    assign rsp_clamped  = clamp_q && (state_q == StResp);
`else
    assign rsp_clamped  = 1'b0;
`endif

endmodule

// File: tb/tb_exp_core_rr_scheduler.sv
// Directed bench for exp_core_rr_scheduler with a behavioural exp core attached.
module tb_exp_core_rr_scheduler;

    localparam int NR  = 4;
    localparam int DW  = 64;
    localparam int LAT = 5;
    localparam real ONE = 1099511627776.0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_x = '0;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready = '0;
    logic [DW-1:0]    rsp_data;
    logic             rsp_clamped;
    logic [DW-1:0]    core_x;
    logic             core_x_valid;
    logic             core_x_ready;
    logic [DW-1:0]    core_y;
    logic             core_y_valid;
    logic             core_y_ready;
    logic             busy;
    logic [15:0]      ops_done;

    int n_checks = 0;
    int n_pass   = 0;

    exp_core_rr_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .FRAC_W(40)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_clamped(rsp_clamped),
        .core_x(core_x), .core_x_valid(core_x_valid), .core_x_ready(core_x_ready),
        .core_y(core_y), .core_y_valid(core_y_valid), .core_y_ready(core_y_ready),
        .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] core_fn(input logic [63:0] x);
        real r;
        r = $exp(real'($signed(x)) / ONE);
        return 64'(longint'(r * ONE));
    endfunction

    // Behavioural core: stalls x acceptance 2 cycles, computes for LAT cycles.
    logic        cbusy;
    int          ccnt;
    int          stall;
    logic [63:0] cx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cbusy <= 1'b0; core_y_valid <= 1'b0; core_y <= '0; ccnt <= 0; stall <= 0;
        end else if (!cbusy) begin
            if (core_x_valid && core_x_ready) begin
                cbusy <= 1'b1; cx <= core_x; ccnt <= LAT; stall <= 0;
            end else if (core_x_valid) begin
                stall <= stall + 1;
            end
        end else if (!core_y_valid) begin
            if (ccnt == 0) begin
                core_y_valid <= 1'b1; core_y <= core_fn(cx);
            end else begin
                ccnt <= ccnt - 1;
            end
        end else if (core_y_ready) begin
            core_y_valid <= 1'b0; cbusy <= 1'b0;
        end
    end
    assign core_x_ready = !cbusy && (stall >= 2);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue(input int p, input logic [63:0] x);
        bit got = 0;
        req_x[p*DW +: DW] = x;
        req_valid[p] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (req_ready[p]) got = 1;
            else @(negedge clk);
        end
        check("accept", 64'(got), 64'd1);
        check("req_ready_onehot", 64'(req_ready), 64'(1 << p));
        @(negedge clk);
        req_valid[p] = 1'b0;
        req_x[p*DW +: DW] = {$urandom, $urandom};
    endtask

    task automatic await_rsp(input int p, input logic [63:0] exp_cx, input logic exp_clamp);
        bit got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid != '0) got = 1;
        end
        check("rsp_arrives", 64'(got), 64'd1);
        check("rsp_valid", 64'(rsp_valid), 64'(1 << p));
        check("core_x_seen", cx, exp_cx);
        check("rsp_data", rsp_data, core_fn(exp_cx));
        check("rsp_clamped", 64'(rsp_clamped), 64'(exp_clamp));
    endtask

    task automatic finish_rsp(input int p);
        rsp_ready[p] = 1'b1;
        @(negedge clk);
        rsp_ready = '0;
        check("rsp_done", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        bit ok;
        longint diff;
        logic [63:0] held;

        // T1 reset state and quiet idle
        #1;
        check("rst_req_ready", 64'(req_ready), 0);
        check("rst_rsp_valid", 64'(rsp_valid), 0);
        check("rst_core_x_valid", 64'(core_x_valid), 0);
        check("rst_core_y_ready", 64'(core_y_ready), 0);
        check("rst_core_x", core_x, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_clamped", 64'(rsp_clamped), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_ops_done", 64'(ops_done), 0);
        do_reset();
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (busy || core_x_valid || req_ready != '0) ok = 0;
        end
        check("idle_20", 64'(ok), 1);

        // T2 exp(0) on port 0
        issue(0, 64'h0);
        await_rsp(0, 64'h0, 1'b0);
        check("t2_one", rsp_data, 64'h0000010000000000);
        finish_rsp(0);
        check("t2_ops", 64'(ops_done), 1);
        check("t2_idle", 64'(busy), 0);

        // T3 exp(-0.5) on port 2
        issue(2, 64'hFFFFFF8000000000);
        await_rsp(2, 64'hFFFFFF8000000000, 1'b0);
        diff = longint'(rsp_data) - 64'sd666887512942;
        if (diff < 0) diff = -diff;
        check("t3_near", 64'(diff < 64'sd1048576), 1);
        finish_rsp(2);
        check("t3_ops", 64'(ops_done), 2);

        // T4 all ports held valid: rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) req_x[i*DW +: DW] = -(64'(i) << 38);
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            ok = 0;
            for (int w = 0; w < 100 && !ok; w++) begin
                @(negedge clk);
                if (rsp_valid != '0) ok = 1;
            end
            check("t4_arrive", 64'(ok), 1);
            check("t4_order", 64'(rsp_valid), 64'(1 << (k % NR)));
            check("t4_data", rsp_data, core_fn(-(64'(k % NR) << 38)));
            if (k == 4) req_valid = '0;
            rsp_ready = '1;
            @(negedge clk);
            rsp_ready = '0;
        end
        check("t4_ops", 64'(ops_done), 5);

        // T5 backpressure on port 1 for 50 cycles
        issue(1, -(64'd3 << 37));
        await_rsp(1, -(64'd3 << 37), 1'b0);
        held = rsp_data;
        req_x[3*DW +: DW] = 64'h0;
        req_valid[3] = 1'b1;
        rsp_ready = 4'b1101;
        ok = 1;
        repeat (50) begin
            @(negedge clk);
            if (rsp_data !== held || rsp_valid !== 4'b0010 || req_ready !== '0) ok = 0;
        end
        check("t5_stable", 64'(ok), 1);
        rsp_ready = '0;
        req_valid[3] = 1'b0;
        finish_rsp(1);
        check("t5_ops", 64'(ops_done), 6);

        // T6 reset during WAIT discards the op
        issue(1, -(64'd1 << 38));
        ok = 0;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (core_y_ready) ok = 1;
        end
        check("t6_in_wait", 64'(ok), 1);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 0);
        check("t6_ops", 64'(ops_done), 0);
        check("t6_core_y_ready", 64'(core_y_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid != '0 || busy) ok = 0;
        end
        check("t6_no_rsp", 64'(ok), 1);

`ifdef EXP_ARB_RANGE_CHECK_EN
        issue(0, 64'h0000004000000000);
        await_rsp(0, 64'h0, 1'b1);
        check("clamp_hi_one", rsp_data, 64'h0000010000000000);
        finish_rsp(0);
        issue(3, 64'hFFFFFE0000000000);
        await_rsp(3, 64'hFFFFFF0000000000, 1'b1);
        finish_rsp(3);
        issue(2, 64'hFFFFFF8000000000);
        await_rsp(2, 64'hFFFFFF8000000000, 1'b0);
        finish_rsp(2);
`else
        issue(0, 64'h0000004000000000);
        await_rsp(0, 64'h0000004000000000, 1'b0);
        finish_rsp(0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
